shift_tx: RTL and testbench

- Parallel-in/serial-out transmitter: the transmit end of the serial link whose receive end is the shift_1 serial-in/parallel-out shift register.
- Captures a W-bit word through a valid/ready handshake, then drives it one bit per ck rising edge on d_out.
- Asserts a frame qualifier while bits are valid, and inserts an optional idle gap between words.
- Drives shift_1's d input directly; frame/done are available to gate or sample the receiver.

---
 rtl/shift_tx.sv | 92 +++++++++
 tb/tb_shift_tx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/shift_tx.sv
// Parallel-in/serial-out transmitter: captures a W-bit word on a valid/ready
// handshake and drives it one bit per clock, with an optional idle gap between words.
module shift_tx #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic         ck,
  input  logic         res,
  input  logic [W-1:0] din,
  input  logic         load,
  output logic         ready,
  output logic         d_out,
  output logic         frame,
  output logic         done
);
  localparam int         BW       = $clog2(W);
  localparam bit         HAS_GAP  = (GAP > 0);
  localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t        r_state, w_state_nx;
  logic [W-1:0]  r_sr, w_sr_nx;
  logic [BW-1:0] r_bcnt, w_bcnt_nx;
  logic [3:0]    r_gcnt, w_gcnt_nx;
  logic          w_last, w_head;
  logic [W-1:0]  w_sr_adv;

  assign w_last   = (r_state == ST_SHIFT) && (r_bcnt == BIT_LAST);
  assign w_head   = MSB_FIRST ? r_sr[W-1] : r_sr[0];
  assign w_sr_adv = MSB_FIRST ? {r_sr[W-2:0], 1'b0} : {1'b0, r_sr[W-1:1]};

  // ready is held low while reset is asserted, even though the state already reads IDLE
  assign ready = res && ((r_state == ST_IDLE) || (w_last && !HAS_GAP));
  assign frame = (r_state == ST_SHIFT);
  assign d_out = frame && w_head;
  assign done  = w_last;

  always_comb begin
    w_state_nx = r_state;
    w_sr_nx    = r_sr;
    w_bcnt_nx  = r_bcnt;
    w_gcnt_nx  = r_gcnt;
    unique case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_sr_nx    = din;
          w_bcnt_nx  = '0;
          w_state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          if (HAS_GAP) begin
            w_gcnt_nx  = '0;
            w_state_nx = ST_GAP;
          end else if (load) begin
            // back-to-back: next word's bit 0 follows with no bubble
            w_sr_nx   = din;
            w_bcnt_nx = '0;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_sr_nx   = w_sr_adv;
          w_bcnt_nx = r_bcnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gcnt == GAP_LAST) w_state_nx = ST_IDLE;
        else                    w_gcnt_nx  = r_gcnt + 1'b1;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_bcnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_sr    <= w_sr_nx;
      r_bcnt  <= w_bcnt_nx;
      r_gcnt  <= w_gcnt_nx;
    end
  end
endmodule

// File: tb/tb_shift_tx.sv
// Scoreboard bench for shift_tx: three configurations (MSB/GAP0, LSB/GAP0, MSB/GAP2)
// share one clock and reset; a tb-side shift register stands in for the receiver.
module tb_shift_tx;
  logic            ck = 1'b0;
  logic            res;
  logic [2:0]      ld;
  logic [2:0][3:0] dn;
  logic [2:0]      rdy, dout, frm, dne;
  logic [3:0]      rx;
  logic [1:0]      sbq [3][$];
  int              n_chk = 0;
  int              n_pass = 0;

  always #5 ck = ~ck;

  shift_tx #(.W(4), .MSB_FIRST(1'b1), .GAP(0)) u0 (
    .ck(ck), .res(res), .din(dn[0]), .load(ld[0]),
    .ready(rdy[0]), .d_out(dout[0]), .frame(frm[0]), .done(dne[0]));
  shift_tx #(.W(4), .MSB_FIRST(1'b0), .GAP(0)) u1 (
    .ck(ck), .res(res), .din(dn[1]), .load(ld[1]),
    .ready(rdy[1]), .d_out(dout[1]), .frame(frm[1]), .done(dne[1]));
  shift_tx #(.W(4), .MSB_FIRST(1'b1), .GAP(2)) u2 (
    .ck(ck), .res(res), .din(dn[2]), .load(ld[2]),
    .ready(rdy[2]), .d_out(dout[2]), .frame(frm[2]), .done(dne[2]));

  // receiver model: plain serial-in shift register, MSB arrives first
  always @(posedge ck) rx <= {rx[2:0], dout[0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // queue {d_out, done} for each of the 4 bits; instance 1 is LSB-first
  task automatic push(input int id, input logic [3:0] w);
    for (int k = 0; k < 4; k++) begin
      logic b;
      b = (id == 1) ? w[k] : w[3-k];
      sbq[id].push_back({b, k == 3});
    end
  endtask

  task automatic send(input int id, input logic [3:0] w);
    @(negedge ck);
    ld[id] = 1'b1;
    dn[id] = w;
    @(posedge ck);
    push(id, w);
    @(negedge ck);
    ld[id] = 1'b0;
  endtask

  always @(negedge ck) begin
    for (int i = 0; i < 3; i++) begin
      if (frm[i]) begin
        if (sbq[i].size() == 0) chk($sformatf("extra_frame%0d", i), 32'(frm[i]), 32'd0);
        else chk($sformatf("bit%0d", i), 32'({dout[i], dne[i]}), 32'(sbq[i].pop_front()));
      end else if (dout[i] || dne[i]) begin
        chk($sformatf("idle_out%0d", i), 32'({dout[i], dne[i]}), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b0;
    ld  = 3'b111;
    dn  = {3{4'hF}};
    #14;
    chk("rst_dout",  32'(dout), 32'd0);
    chk("rst_frame", 32'(frm),  32'd0);
    chk("rst_done",  32'(dne),  32'd0);
    chk("rst_ready", 32'(rdy),  32'd0);
    #2 ld = 3'b000;
    #1 res = 1'b1;
    #1;
    chk("post_rst_ready", 32'(rdy), 32'h7);
    chk("post_rst_frame", 32'(frm), 32'd0);

    // single word MSB first
    send(0, 4'b1011);
    repeat (2) @(negedge ck);
    @(negedge ck);
    chk("rdy_last_bit", 32'(rdy[0]), 32'd1);
    @(negedge ck);
    chk("single_idle_rdy", 32'(rdy[0]), 32'd1);
    chk("single_idle_frm", 32'(frm[0]), 32'd0);

    // LSB first
    send(1, 4'b1011);
    repeat (4) @(negedge ck);
    chk("lsb_idle_rdy", 32'(rdy[1]), 32'd1);

    // back-to-back A then 5, din switched during the last-bit cycle
    @(negedge ck);
    ld[0] = 1'b1;
    dn[0] = 4'hA;
    @(posedge ck);
    push(0, 4'hA);
    for (int k = 0; k < 8; k++) begin
      @(negedge ck);
      chk($sformatf("b2b_frame%0d", k), 32'(frm[0]), 32'd1);
      if (k == 3) begin
        dn[0] = 4'h5;
        push(0, 4'h5);
      end
      if (k == 7) ld[0] = 1'b0;
    end
    @(negedge ck);
    chk("b2b_end_frm", 32'(frm[0]), 32'd0);

    // gap: pulse during bit 1 is ignored
    @(negedge ck);
    ld[2] = 1'b1;
    dn[2] = 4'h3;
    @(posedge ck);
    push(2, 4'h3);
    @(negedge ck) ld[2] = 1'b0;
    @(negedge ck);
    ld[2] = 1'b1;
    dn[2] = 4'hF;
    @(negedge ck) ld[2] = 1'b0;
    @(negedge ck);
    chk("gap_last_rdy", 32'(rdy[2]), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge ck);
      chk($sformatf("gap%0d_frm", k), 32'(frm[2]), 32'd0);
      chk($sformatf("gap%0d_rdy", k), 32'(rdy[2]), 32'd0);
    end
    @(negedge ck);
    chk("gap_done_rdy", 32'(rdy[2]), 32'd1);
    chk("gap_done_frm", 32'(frm[2]), 32'd0);

    // loopback into receiver model
    send(0, 4'b1101);
    repeat (4) @(posedge ck);
    #1 chk("loopback_q", 32'(rx), 32'hD);

    // reset mid-word
    send(0, 4'b1111);
    @(posedge ck);
    #3 res = 1'b0;
    #1;
    chk("abort_dout",  32'(dout[0]), 32'd0);
    chk("abort_frame", 32'(frm[0]),  32'd0);
    chk("abort_done",  32'(dne[0]),  32'd0);
    chk("abort_ready", 32'(rdy),     32'd0);
    sbq[0].delete();
    @(negedge ck);
    #2 res = 1'b1;
    repeat (5) @(negedge ck);
    chk("abort_idle_frm", 32'(frm[0]), 32'd0);
    chk("abort_idle_rdy", 32'(rdy),    32'h7);

    for (int i = 0; i < 3; i++)
      chk($sformatf("sb_empty%0d", i), 32'(sbq[i].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
